// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: fetch stage in front of the instruction memory.
// Owns the PC, issues one word read at a time, waits MEM_LATENCY cycles,
// buffers {instruction, pc} and hands it to decode over valid/ready.
// Optional feature macro: IFU_SKID_BUFFER_EN (2-entry output buffer;
// the default build uses a 1-entry buffer).
module instruction_fetch_unit #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
    parameter int                    MEM_LATENCY = 1,
    parameter longint                ADDR_LIMIT  = 8192
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic [ADDR_WIDTH-1:0] imem_address,
    output logic                  imem_read_enable,
    input  logic [DATA_WIDTH-1:0] imem_data,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic                  fetch_fault
);

`ifdef IFU_SKID_BUFFER_EN
    localparam logic [1:0] BUF_CAP = 2'd2;
`else
    localparam logic [1:0] BUF_CAP = 2'd1;
`endif

    localparam int                    LAT_W     = (MEM_LATENCY < 2) ? 1 : $clog2(MEM_LATENCY + 1);
    localparam logic [LAT_W-1:0]      LAT_LOAD  = LAT_W'(MEM_LATENCY);
    localparam logic [LAT_W-1:0]      LAT_ONE   = LAT_W'(1);
    // One extra bit so a limit of exactly 2^ADDR_WIDTH is representable.
    localparam logic [ADDR_WIDTH:0]   LIMIT_EXT = (ADDR_WIDTH + 1)'(ADDR_LIMIT);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_FAULT} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic [LAT_W-1:0]        lat_q, lat_d;
    logic                    fault_q, fault_d;
    logic                    rd_en_q, rd_en_d;
    logic                    valid_q, valid_d;
    logic [1:0]              cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   buf_data_q [2];
    logic [DATA_WIDTH-1:0]   buf_data_d [2];
    logic [ADDR_WIDTH-1:0]   buf_pc_q [2];
    logic [ADDR_WIDTH-1:0]   buf_pc_d [2];
    logic                    push_s;
    logic                    pop_s;
    logic [1:0]              wr_slot_s;

    // Fetch FSM: next state, PC, latency counter and fault flag; redirect overrides everything.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        lat_d   = lat_q;
        fault_d = fault_q;
        push_s  = 1'b0;
        case (state_q)
            S_IDLE: begin
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if ({1'b0, pc_q} >= LIMIT_EXT) begin
                    state_d = S_FAULT;
                    fault_d = 1'b1;
                end else if (!stall && (cnt_q < BUF_CAP)) begin
                    // Occupancy is taken before any same-cycle pop on purpose.
                    state_d = S_WAIT;
                    lat_d   = LAT_LOAD;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_WAIT: begin
                if (lat_q == LAT_ONE) begin
                    push_s  = 1'b1;
                    pc_d    = pc_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                    state_d = S_ISSUE;
                end else begin
                    lat_d = lat_q - LAT_ONE;
                end
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (redirect_valid) begin
            // Abandon any in-flight read: its data is never buffered.
            state_d = S_ISSUE;
            pc_d    = redirect_pc;
            fault_d = 1'b0;
            push_s  = 1'b0;
            lat_d   = '0;
        end else begin
            state_d = state_d;
        end
        rd_en_d = (state_d == S_WAIT);
    end

    // Output buffer: shift-style queue with slot 0 as head; push and pop may coincide.
    always_comb begin
        pop_s      = valid_q & instr_ready;
        wr_slot_s  = cnt_q - {1'b0, pop_s};
        cnt_d      = cnt_q;
        buf_data_d = buf_data_q;
        buf_pc_d   = buf_pc_q;
        if (redirect_valid) begin
            cnt_d = 2'd0;
        end else begin
            if (pop_s) begin
                buf_data_d[0] = buf_data_q[1];
                buf_pc_d[0]   = buf_pc_q[1];
            end else begin
                buf_data_d[0] = buf_data_q[0];
            end
            if (push_s) begin
                if (wr_slot_s == 2'd0) begin
                    buf_data_d[0] = imem_data;
                    buf_pc_d[0]   = pc_q;
                end else begin
                    buf_data_d[1] = imem_data;
                    buf_pc_d[1]   = pc_q;
                end
            end else begin
                buf_pc_d[1] = buf_pc_d[1];
            end
            cnt_d = cnt_q + {1'b0, push_s} - {1'b0, pop_s};
        end
        valid_d = (cnt_d != 2'd0);
    end

    // State, PC and buffer registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            lat_q   <= '0;
            fault_q <= 1'b0;
            rd_en_q <= 1'b0;
            valid_q <= 1'b0;
            cnt_q   <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                buf_data_q[i] <= '0;
                buf_pc_q[i]   <= '0;
            end
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            lat_q      <= lat_d;
            fault_q    <= fault_d;
            rd_en_q    <= rd_en_d;
            valid_q    <= valid_d;
            cnt_q      <= cnt_d;
            buf_data_q <= buf_data_d;
            buf_pc_q   <= buf_pc_d;
        end
    end

    assign imem_address     = pc_q;
    assign imem_read_enable = rd_en_q;
    assign instr_valid      = valid_q;
    assign instr            = buf_data_q[0];
    assign instr_pc         = buf_pc_q[0];
    assign fetch_fault      = fault_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: start-up vector table,
// transfer scoreboard, and directed backpressure/redirect/stall/fault/reset cases.
module tb_instruction_fetch_unit;

`ifdef IFU_SKID_BUFFER_EN
    localparam int EXP_DEPTH = 2;
`else
    localparam int EXP_DEPTH = 1;
`endif

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // main instance: default parameters
    logic        rst_n, stall, redirect_valid, instr_ready;
    logic [31:0] redirect_pc, imem_address, imem_data, instr, instr_pc;
    logic        imem_read_enable, instr_valid, fetch_fault;

    // second instance: MEM_LATENCY=3, ADDR_LIMIT=4
    logic        rst_n_b, stall_b, redirect_valid_b, instr_ready_b;
    logic [31:0] redirect_pc_b, imem_address_b, imem_data_b, instr_b, instr_pc_b;
    logic        imem_read_enable_b, instr_valid_b, fetch_fault_b;

    int n_checks = 0;
    int n_fail   = 0;
    int n_xfer   = 0;
    logic [31:0] exp_q [$];
    logic [31:0] got_b [$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hC0DE_0000 + a * 32'd17;
    endfunction

    assign imem_data   = imem_read_enable   ? mem_word(imem_address)   : 32'hDEAD_BEEF;
    assign imem_data_b = imem_read_enable_b ? mem_word(imem_address_b) : 32'hDEAD_BEEF;

    instruction_fetch_unit u_dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_address(imem_address), .imem_read_enable(imem_read_enable),
        .imem_data(imem_data), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc), .fetch_fault(fetch_fault)
    );

    instruction_fetch_unit #(.MEM_LATENCY(3), .ADDR_LIMIT(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n_b), .stall(stall_b),
        .redirect_valid(redirect_valid_b), .redirect_pc(redirect_pc_b),
        .imem_address(imem_address_b), .imem_read_enable(imem_read_enable_b),
        .imem_data(imem_data_b), .instr_valid(instr_valid_b), .instr_ready(instr_ready_b),
        .instr(instr_b), .instr_pc(instr_pc_b), .fetch_fault(fetch_fault_b)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_seq(input logic [31:0] start);
        for (int k = 0; k < 64; k++) exp_q.push_back(start + 32'(k));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // scoreboard for the main instance: compare each transfer, restart on redirect
    always @(posedge clk) begin
        if (rst_n) begin
            if (instr_valid && instr_ready) begin
                n_xfer++;
                if (exp_q.size() == 0) begin
                    check("sb_underflow", 64'(instr_pc), 64'hFFFF_FFFF);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    check("sb_pc", 64'(instr_pc), 64'(e));
                    check("sb_instr", 64'(instr), 64'(mem_word(e)));
                end
            end
            if (redirect_valid) begin
                exp_q.delete();
                push_seq(redirect_pc);
            end
        end
    end

    // transfer recorder for the second instance
    always @(posedge clk) begin
        if (rst_n_b && instr_valid_b && instr_ready_b) begin
            got_b.push_back(instr_pc_b);
            check("b_instr", 64'(instr_b), 64'(mem_word(instr_pc_b)));
        end
    end

    typedef struct {
        logic        ready;
        logic        exp_valid;
        logic [31:0] exp_ipc;
        logic        exp_re;
        logic [31:0] exp_addr;
    } vec_t;
    vec_t tbl [9];

    initial begin
        int          issues, cnt, xfer0;
        logic        prev_re, ok;
        logic [31:0] sa;

`ifdef IFU_SKID_BUFFER_EN
        tbl[0] = '{1'b1, 1'b0, 32'd0, 1'b0, 32'd0};
        tbl[1] = '{1'b1, 1'b0, 32'd0, 1'b1, 32'd0};
        tbl[2] = '{1'b1, 1'b1, 32'd0, 1'b0, 32'd1};
        tbl[3] = '{1'b1, 1'b0, 32'd0, 1'b1, 32'd1};
        tbl[4] = '{1'b1, 1'b1, 32'd1, 1'b0, 32'd2};
        tbl[5] = '{1'b1, 1'b0, 32'd0, 1'b1, 32'd2};
        tbl[6] = '{1'b1, 1'b1, 32'd2, 1'b0, 32'd3};
        tbl[7] = '{1'b1, 1'b0, 32'd0, 1'b1, 32'd3};
        tbl[8] = '{1'b1, 1'b1, 32'd3, 1'b0, 32'd4};
`else
        tbl[0] = '{1'b1, 1'b0, 32'd0, 1'b0, 32'd0};
        tbl[1] = '{1'b1, 1'b0, 32'd0, 1'b1, 32'd0};
        tbl[2] = '{1'b1, 1'b1, 32'd0, 1'b0, 32'd1};
        tbl[3] = '{1'b1, 1'b0, 32'd0, 1'b0, 32'd1};
        tbl[4] = '{1'b1, 1'b0, 32'd0, 1'b1, 32'd1};
        tbl[5] = '{1'b1, 1'b1, 32'd1, 1'b0, 32'd2};
        tbl[6] = '{1'b1, 1'b0, 32'd0, 1'b0, 32'd2};
        tbl[7] = '{1'b1, 1'b0, 32'd0, 1'b1, 32'd2};
        tbl[8] = '{1'b1, 1'b1, 32'd2, 1'b0, 32'd3};
`endif

        rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0; instr_ready = 1'b1;
        rst_n_b = 1'b0; stall_b = 1'b0; redirect_valid_b = 1'b0; redirect_pc_b = 32'd0; instr_ready_b = 1'b1;
        step(); step();

        // reset state
        check("rst_addr",  64'(imem_address), 64'd0);
        check("rst_re",    64'(imem_read_enable), 64'd0);
        check("rst_valid", 64'(instr_valid), 64'd0);
        check("rst_instr", 64'(instr), 64'd0);
        check("rst_ipc",   64'(instr_pc), 64'd0);
        check("rst_fault", 64'(fetch_fault), 64'd0);

        // start-up timing table (entry i sampled after edge E_i)
        exp_q.delete();
        push_seq(32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 9; i++) begin
            instr_ready = tbl[i].ready;
            step();
            check("tbl_valid", 64'(instr_valid), 64'(tbl[i].exp_valid));
            check("tbl_re",    64'(imem_read_enable), 64'(tbl[i].exp_re));
            check("tbl_addr",  64'(imem_address), 64'(tbl[i].exp_addr));
            if (tbl[i].exp_valid) begin
                check("tbl_ipc",   64'(instr_pc), 64'(tbl[i].exp_ipc));
                check("tbl_instr", 64'(instr), 64'(mem_word(tbl[i].exp_ipc)));
            end
        end

        // backpressure: redirect to 0x10 and hold instr_ready low
        instr_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h10;
        step();
        redirect_valid = 1'b0;
        issues = 0; prev_re = imem_read_enable; ok = 1'b1;
        if (imem_read_enable) issues++;
        for (int i = 0; i < 12; i++) begin
            step();
            if (imem_read_enable && !prev_re) issues++;
            prev_re = imem_read_enable;
            if (i >= 2 && (!instr_valid || instr_pc !== 32'h10 || instr !== mem_word(32'h10))) ok = 1'b0;
        end
        check("hold_stable", 64'(ok), 64'd1);
        check("hold_issues", 64'(issues), 64'(EXP_DEPTH));
        check("hold_re_off", 64'(imem_read_enable), 64'd0);
        xfer0 = n_xfer;
        instr_ready = 1'b1;
        for (int i = 0; i < 12; i++) step();
        check("hold_release_flow", 64'((n_xfer - xfer0) >= 3), 64'd1);

        // redirect on the capture edge of PC=1
        redirect_valid = 1'b1; redirect_pc = 32'd0;
        step();
        redirect_valid = 1'b0;
        cnt = 0;
        while (cnt < 40 && !(imem_read_enable && imem_address == 32'd1)) begin step(); cnt++; end
        check("redir_reach_pc1", 64'(imem_read_enable && imem_address == 32'd1), 64'd1);
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        step();
        redirect_valid = 1'b0;
        check("redir_empty", 64'(instr_valid), 64'd0);
        step();
        check("redir_lat_valid", 64'(instr_valid), 64'd0);
        step();
        check("redir_first_valid", 64'(instr_valid), 64'd1);
        check("redir_first_pc", 64'(instr_pc), 64'h40);
        for (int i = 0; i < 6; i++) step();

        // stall during WAIT: current read completes, no new issue until release
        instr_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h20;
        step();
        redirect_valid = 1'b0;
        cnt = 0;
        while (cnt < 20 && !imem_read_enable) begin step(); cnt++; end
        check("stall_reach_wait", 64'(imem_read_enable), 64'd1);
        sa = imem_address;
        stall = 1'b1;
        step();
        check("stall_buffered_v", 64'(instr_valid), 64'd1);
        check("stall_buffered_pc", 64'(instr_pc), 64'(sa));
        ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            if (imem_read_enable) ok = 1'b0;
        end
        check("stall_no_issue", 64'(ok), 64'd1);
        stall = 1'b0; instr_ready = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (imem_read_enable) ok = 1'b1;
        end
        check("stall_resume", 64'(ok), 64'd1);
        for (int i = 0; i < 6; i++) step();
        check("main_no_fault", 64'(fetch_fault), 64'd0);

        // second instance: fault at ADDR_LIMIT=4
        got_b.delete();
        rst_n_b = 1'b1;
        cnt = 0;
        while (cnt < 80 && !fetch_fault_b) begin step(); cnt++; end
        check("fault_set", 64'(fetch_fault_b), 64'd1);
        check("fault_re_off", 64'(imem_read_enable_b), 64'd0);
        check("fault_count", 64'(got_b.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < got_b.size()) check("fault_seq_pc", 64'(got_b[i]), 64'(i));
        end
        redirect_valid_b = 1'b1; redirect_pc_b = 32'd0;
        step();
        redirect_valid_b = 1'b0;
        check("fault_cleared", 64'(fetch_fault_b), 64'd0);
        got_b.delete();
        cnt = 0;
        while (cnt < 20 && got_b.size() == 0) begin step(); cnt++; end
        check("fault_resume", 64'(got_b.size() != 0), 64'd1);
        if (got_b.size() != 0) check("fault_resume_pc", 64'(got_b[0]), 64'd0);

        // asynchronous reset mid-WAIT (MEM_LATENCY=3)
        instr_ready_b = 1'b0; redirect_valid_b = 1'b1; redirect_pc_b = 32'd2;
        step();
        redirect_valid_b = 1'b0;
        cnt = 0;
        while (cnt < 10 && !imem_read_enable_b) begin step(); cnt++; end
        check("arst_reach_wait", 64'(imem_read_enable_b), 64'd1);
        step();
        #2 rst_n_b = 1'b0;
        #1;
        check("arst_addr",  64'(imem_address_b), 64'd0);
        check("arst_re",    64'(imem_read_enable_b), 64'd0);
        check("arst_valid", 64'(instr_valid_b), 64'd0);
        check("arst_instr", 64'(instr_b), 64'd0);
        check("arst_ipc",   64'(instr_pc_b), 64'd0);
        check("arst_fault", 64'(fetch_fault_b), 64'd0);
        step(); step();
        got_b.delete();
        rst_n_b = 1'b1; instr_ready_b = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            if (instr_valid_b) ok = 1'b0;
        end
        check("arst_no_stale", 64'(ok), 64'd1);
        step();
        check("arst_first_valid", 64'(instr_valid_b), 64'd1);
        check("arst_first_pc", 64'(instr_pc_b), 64'd0);
        step();
        check("arst_no_prior_xfer", 64'(got_b.size()), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
